// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants for the register-bank write arbiter.
// FSM state encoding and default hold limit.
package reg_write_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  localparam int MAXHOLD_DEF = 4;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester/register-bank bundle for the write arbiter.
// master drives requests, slave is the arbiter.
interface reg_write_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 3,
  parameter int DW   = 16
);

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] data;
  logic [NREQ-1:0]    gnt;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic               busy;

  modport master (
    output req, addr, data,
    input  gnt, wr_en, wr_addr, wr_data, busy
  );

  modport slave (
    input  req, addr, data,
    output gnt, wr_en, wr_addr, wr_data, busy
  );

endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin search starting after last_owner.
// pick is one-hot; valid flags that any candidate was found.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int OW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   last_owner,
  output logic [NREQ-1:0] pick,
  output logic            valid
);

  always_comb begin
    int unsigned idx;
    idx   = 0;
    pick  = '0;
    valid = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_owner) + k) % NREQ;
      if (!valid && req[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one register-bank write port
// among NREQ requesters, with a bounded hold per grant.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int AW       = 3,
  parameter int DW       = 16,
  parameter int MAXHOLD  = MAXHOLD_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic clk,
  input  logic clr,
  reg_write_arbiter_if.slave bus
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAXHOLD) + 1;

  arb_state_t state, state_n;

  logic [NREQ-1:0] gnt_q, gnt_n;
  logic [NREQ-1:0] cand, pick;
  logic [OW-1:0]   last_q, last_n, pick_idx;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            valid, held, hit_max;

  // While owned, the owner is excluded so a handover
  // always lands on a different requester.
  assign cand = (state == OWNED) ? (bus.req & ~gnt_q)
                                 : bus.req;

  rr_pick #(
    .NREQ (NREQ),
    .OW   (OW)
  ) u_pick (
    .req        (cand),
    .last_owner (last_q),
    .pick       (pick),
    .valid      (valid)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        sel_addr = sel_addr | bus.addr[i*AW +: AW];
        sel_data = sel_data | bus.data[i*DW +: DW];
      end
      if (pick[i])
        pick_idx = OW'(i);
    end
  end

  assign held    = |(gnt_q & bus.req);
  assign hit_max = (cnt_q == CW'(MAXHOLD));

  always_comb begin
    state_n = state;
    gnt_n   = gnt_q;
    last_n  = last_q;
    cnt_n   = cnt_q;
    unique case (state)
      IDLE: begin
        if (valid) begin
          state_n = OWNED;
          gnt_n   = pick;
          last_n  = pick_idx;
          cnt_n   = CW'(1);
        end
      end
      OWNED: begin
        if (!held || hit_max) begin
          if (valid) begin
            gnt_n  = pick;
            last_n = pick_idx;
            cnt_n  = CW'(1);
          end else if (!held) begin
            state_n = IDLE;
            gnt_n   = '0;
            cnt_n   = '0;
          end else begin
            cnt_n = CW'(1);
          end
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= IDLE;
      gnt_q  <= '0;
      last_q <= OW'(NREQ - 1);
      cnt_q  <= '0;
    end else begin
      state  <= state_n;
      gnt_q  <= gnt_n;
      last_q <= last_n;
      cnt_q  <= cnt_n;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = |gnt_q;
  assign bus.wr_addr = sel_addr;
  assign bus.wr_data = sel_data;
  assign bus.wr_en   = held &&
                       !((ZERO_REG != 0) && (sel_addr == '0));

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed and random checks for reg_write_arbiter,
// with ZERO_REG=1 and ZERO_REG=0 instances sharing stimulus.
module tb_reg_write_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 3;
  localparam int DW   = 16;

  logic clk = 1'b0;
  logic clr;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] data;

  int tests = 0;
  int fails = 0;
  int w [NREQ];
  int maxw;
  logic [DW-1:0] exp_data;
  logic [AW-1:0] exp_addr;
  logic          exp_en;

  always #5 clk = ~clk;

  reg_write_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus_z ();
  reg_write_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus_n ();

  assign bus_z.req  = req;
  assign bus_z.addr = addr;
  assign bus_z.data = data;
  assign bus_n.req  = req;
  assign bus_n.addr = addr;
  assign bus_n.data = data;

  reg_write_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .MAXHOLD(4), .ZERO_REG(1)
  ) dut_z (
    .clk (clk),
    .clr (clr),
    .bus (bus_z.slave)
  );

  reg_write_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .MAXHOLD(4), .ZERO_REG(0)
  ) dut_n (
    .clk (clk),
    .clr (clr),
    .bus (bus_n.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    clr = 1'b1;
    req = '0;
    cyc();
    cyc();
    clr = 1'b0;
  endtask

  initial begin
    clr  = 1'b1;
    req  = '0;
    addr = {3'd3, 3'd2, 3'd5};
    data = {16'h3333, 16'h2222, 16'hABCD};
    cyc();
    cyc();

    // reset state, sampled while clr is high
    #1;
    chk("rst_gnt", 32'(bus_z.gnt), 32'h0);
    chk("rst_busy", 32'(bus_z.busy), 32'h0);
    chk("rst_wr_en", 32'(bus_z.wr_en), 32'h0);
    chk("rst_wr_addr", 32'(bus_z.wr_addr), 32'h0);
    chk("rst_wr_data", 32'(bus_z.wr_data), 32'h0);
    cyc();

    // single requester, one-cycle latency
    clr = 1'b0;
    req = 3'b001;
    #1;
    chk("lat_gnt_before", 32'(bus_z.gnt), 32'h0);
    cyc();
    #1;
    chk("single_gnt", 32'(bus_z.gnt), 32'h1);
    chk("single_wr_en", 32'(bus_z.wr_en), 32'h1);
    chk("single_wr_addr", 32'(bus_z.wr_addr), 32'h5);
    chk("single_wr_data", 32'(bus_z.wr_data), 32'hABCD);
    chk("single_busy", 32'(bus_z.busy), 32'h1);
    req = 3'b000;
    #1;
    chk("drop_wr_en", 32'(bus_z.wr_en), 32'h0);
    cyc();
    #1;
    chk("drop_gnt", 32'(bus_z.gnt), 32'h0);
    chk("drop_wr_data", 32'(bus_z.wr_data), 32'h0);

    // all requesting: 0,1,2,0 with 4 cycles each
    addr = {3'd3, 3'd2, 3'd1};
    do_reset();
    req = 3'b111;
    cyc();
    for (int i = 0; i < 16; i++) begin
      #1;
      chk($sformatf("rr_gnt_%0d", i), 32'(bus_z.gnt),
          32'(3'b001 << ((i / 4) % 3)));
      chk($sformatf("rr_wr_addr_%0d", i), 32'(bus_z.wr_addr),
          32'(((i / 4) % 3) + 1));
      chk($sformatf("rr_wr_en_%0d", i), 32'(bus_z.wr_en), 32'h1);
      cyc();
    end

    // lone requester keeps the grant past MAXHOLD
    do_reset();
    req = 3'b010;
    cyc();
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("solo_gnt_%0d", i), 32'(bus_z.gnt), 32'h2);
      chk($sformatf("solo_wr_en_%0d", i), 32'(bus_z.wr_en), 32'h1);
      chk($sformatf("solo_data_%0d", i), 32'(bus_z.wr_data), 32'h2222);
      cyc();
    end

    // write to register 0
    do_reset();
    addr = {3'd3, 3'd2, 3'd0};
    req  = 3'b001;
    cyc();
    #1;
    chk("zr1_gnt", 32'(bus_z.gnt), 32'h1);
    chk("zr1_wr_en", 32'(bus_z.wr_en), 32'h0);
    chk("zr0_gnt", 32'(bus_n.gnt), 32'h1);
    chk("zr0_wr_en", 32'(bus_n.wr_en), 32'h1);
    cyc();

    // clr in the middle of owner 1's burst
    addr = {3'd3, 3'd2, 3'd1};
    do_reset();
    req = 3'b010;
    cyc();
    #1;
    chk("clr_burst_gnt", 32'(bus_z.gnt), 32'h2);
    cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    req = 3'b111;
    #1;
    chk("clr_abort_gnt", 32'(bus_z.gnt), 32'h0);
    chk("clr_abort_wr_en", 32'(bus_z.wr_en), 32'h0);
    cyc();
    #1;
    chk("clr_next_gnt", 32'(bus_z.gnt), 32'h1);
    cyc();

    // random sticky requests
    do_reset();
    maxw = 0;
    for (int i = 0; i < NREQ; i++) w[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
        addr[i*AW +: AW] = AW'($urandom_range(0, 7));
        data[i*DW +: DW] = DW'($urandom);
      end
      #1;
      exp_data = '0;
      exp_addr = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (bus_z.gnt[i]) begin
          exp_data = data[i*DW +: DW];
          exp_addr = addr[i*AW +: AW];
        end
      end
      exp_en = |(bus_z.gnt & req);
      chk("rand_onehot", 32'($onehot0(bus_z.gnt)), 32'h1);
      chk("rand_wr_data", 32'(bus_z.wr_data), 32'(exp_data));
      chk("rand_wr_en_z", 32'(bus_z.wr_en),
          32'(exp_en && (exp_addr != '0)));
      chk("rand_wr_en_n", 32'(bus_n.wr_en), 32'(|(bus_n.gnt & req)));
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && !bus_z.gnt[i]) w[i]++;
        else w[i] = 0;
        if (w[i] > maxw) maxw = w[i];
      end
      cyc();
    end
    chk("rand_max_wait_ok", 32'(maxw <= (NREQ - 1) * 4 + 1), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
